// File: rtl/fixed_point_complex_multiplier_if.sv
// Streaming bus of the fixed-point complex multiplier: operand channel,
// result channel, and the sticky-overflow side band.
interface fixed_point_complex_multiplier_if #(
  parameter int WIDTH = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] a_re;
  logic signed [WIDTH-1:0] a_im;
  logic signed [WIDTH-1:0] b_re;
  logic signed [WIDTH-1:0] b_im;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] p_re;
  logic signed [WIDTH-1:0] p_im;
  logic                    sat_re;
  logic                    sat_im;
  logic                    clear_flags;
  logic                    overflow_sticky;

  modport slave (
    input  in_valid, a_re, a_im, b_re, b_im, out_ready, clear_flags,
    output in_ready, out_valid, p_re, p_im, sat_re, sat_im, overflow_sticky
  );

  modport master (
    output in_valid, a_re, a_im, b_re, b_im, out_ready, clear_flags,
    input  in_ready, out_valid, p_re, p_im, sat_re, sat_im, overflow_sticky
  );
endinterface

// File: rtl/fixed_point_complex_multiplier.sv
// Three-stage signed fixed-point complex multiplier with truncate/round,
// saturation and a single global stall driven by downstream backpressure.
module fixed_point_complex_multiplier #(
  parameter int WIDTH             = 16,
  parameter int EXP_WIDTH_A       = 15,
  parameter int EXP_WIDTH_B       = 5,
  parameter int EXP_WIDTH_PRODUCT = 5,
  parameter int ROUND             = 0
) (
  input logic                             clk,
  input logic                             reset,
  fixed_point_complex_multiplier_if.slave bus
);
  localparam int S      = EXP_WIDTH_A + EXP_WIDTH_B - EXP_WIDTH_PRODUCT;
  localparam int STAGES = 3;
  localparam int PW     = 2 * WIDTH;
  localparam int SW     = 2 * WIDTH + 2;  // sum bit + headroom for rounding add

  localparam logic signed [SW-1:0] MAXV = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = {{(SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic signed [SW-1:0] RND  = (ROUND != 0) ? (SW'(1) <<< (S-1)) : '0;

  generate
    if (S < 1) begin : g_bad_shift
      $error("fixed_point_complex_multiplier: shift amount must be >= 1");
    end
  endgenerate

  logic [STAGES:1]         vld_pipe_q;
  logic signed [WIDTH-1:0] ar_q, ai_q, br_q, bi_q;
  logic signed [PW-1:0]    rr_q, ii_q, ri_q, ir_q;
  logic signed [WIDTH-1:0] p_re_q, p_im_q, p_re_d, p_im_d;
  logic                    sat_re_q, sat_im_q, sat_re_d, sat_im_d;
  logic                    sticky_q;
  logic                    adv;
  logic signed [SW-1:0]    re_w, im_w;

  assign adv = bus.out_ready || !vld_pipe_q[STAGES];

  // Returns {saturated, value}: shift first, then clamp the wide result.
  function automatic logic [WIDTH:0] rnd_sat(input logic signed [SW-1:0] x);
    logic signed [SW-1:0] r;
    r = (x + RND) >>> S;
    if (r > MAXV)      rnd_sat = {1'b1, MAXV[WIDTH-1:0]};
    else if (r < MINV) rnd_sat = {1'b1, MINV[WIDTH-1:0]};
    else               rnd_sat = {1'b0, r[WIDTH-1:0]};
  endfunction

  always_comb begin
    re_w = SW'(rr_q) - SW'(ii_q);
    im_w = SW'(ri_q) + SW'(ir_q);
    {sat_re_d, p_re_d} = rnd_sat(re_w);
    {sat_im_d, p_im_d} = rnd_sat(im_w);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe_q <= '0;
      ar_q       <= '0;
      ai_q       <= '0;
      br_q       <= '0;
      bi_q       <= '0;
      rr_q       <= '0;
      ii_q       <= '0;
      ri_q       <= '0;
      ir_q       <= '0;
      p_re_q     <= '0;
      p_im_q     <= '0;
      sat_re_q   <= 1'b0;
      sat_im_q   <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      if (adv) begin
        vld_pipe_q <= {vld_pipe_q[STAGES-1:1], bus.in_valid};
        ar_q       <= bus.a_re;
        ai_q       <= bus.a_im;
        br_q       <= bus.b_re;
        bi_q       <= bus.b_im;
        rr_q       <= ar_q * br_q;
        ii_q       <= ai_q * bi_q;
        ri_q       <= ar_q * bi_q;
        ir_q       <= ai_q * br_q;
        p_re_q     <= p_re_d;
        p_im_q     <= p_im_d;
        sat_re_q   <= sat_re_d;
        sat_im_q   <= sat_im_d;
      end
      // A saturated result leaving the block beats a simultaneous clear.
      if (vld_pipe_q[STAGES] && bus.out_ready && (sat_re_q || sat_im_q))
        sticky_q <= 1'b1;
      else if (bus.clear_flags)
        sticky_q <= 1'b0;
    end
  end

  assign bus.in_ready        = adv;
  assign bus.out_valid       = vld_pipe_q[STAGES];
  assign bus.p_re            = p_re_q;
  assign bus.p_im            = p_im_q;
  assign bus.sat_re          = sat_re_q;
  assign bus.sat_im          = sat_im_q;
  assign bus.overflow_sticky = sticky_q;
endmodule

// File: doc/fixed_point_complex_multiplier.md
Name: fixed_point_complex_multiplier

Overview:
- Pipelined, parametrised signed fixed-point complex multiplier: (a_re + j·a_im)·(b_re + j·b_im).
- Next generation of the scalar fixed_point_multiplier. Adds:
  - configurable width and per-operand Q formats;
  - truncate or round mode;
  - saturation flags;
  - valid/ready streaming with backpressure.
- Sits between the FFT butterfly and the twiddle ROM in the spectrum pipeline.

Parameters:
- WIDTH, 16: bit width of every operand and result component (signed two's complement).
- EXP_WIDTH_A, 15: fractional bits of a_re/a_im.
- EXP_WIDTH_B, 5: fractional bits of b_re/b_im.
- EXP_WIDTH_PRODUCT, 5: fractional bits of p_re/p_im.
- ROUND, 0: 0 = truncate (arithmetic shift, toward −inf); 1 = round half up (add 2^(S−1) before shift).

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input operands valid
- in_ready  out  1  block accepts operands this cycle
- a_re, a_im  in  WIDTH  operand A, Q(EXP_WIDTH_A)
- b_re, b_im  in  WIDTH  operand B, Q(EXP_WIDTH_B)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- p_re, p_im  out  WIDTH  product, Q(EXP_WIDTH_PRODUCT)
- sat_re, sat_im  out  1  this result component was saturated; qualified by out_valid
- clear_flags  in  1  clears overflow_sticky
- overflow_sticky  out  1  set by any saturation on an accepted output; held until cleared

Behaviour:
- Shift amount S = EXP_WIDTH_A + EXP_WIDTH_B − EXP_WIDTH_PRODUCT. S ≥ 1 is required; S < 1 is an elaboration-time error.
- Three-stage pipeline, latency 3 cycles from accepted input to out_valid:
  - S1 registers the operands.
  - S2 registers four full 2·WIDTH products: ar·br, ai·bi, ar·bi, ai·br.
  - S3 computes re = ar·br − ai·bi and im = ar·bi + ai·br at 2·WIDTH+1 bits, then rounds/shifts by S, saturates and registers.
- Saturation limits: clamp to [−2^(WIDTH−1), 2^(WIDTH−1)−1]. sat_x = 1 when clamping occurred.
- Handshake:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - in_ready = out_ready || !out_valid. This is a global stall: all stages advance together when in_ready = 1 and hold otherwise.
  - Per-stage valid bits propagate. Bubbles (in_valid = 0 while in_ready = 1) insert invalid slots.
- Stall: while out_valid && !out_ready, p_re, p_im, sat_re, sat_im, out_valid and all stage registers hold.
- overflow_sticky: set on an output transfer with sat_re || sat_im. If clear_flags and a set event occur in the same cycle, set wins.
- Reset (synchronous, any time including mid-stream):
  - all stage valids, out_valid and overflow_sticky go to 0;
  - p_re, p_im, sat_re, sat_im go to 0;
  - in_flight data is discarded;
  - in_ready = 1 in the cycle after reset deasserts.
- Corner case: a = b = −2^(WIDTH−1) + j·0 gives a positive product and must saturate positive, not wrap.
- No X propagation: outputs are deterministic when out_valid = 0.

Test Plan (WIDTH=16, EXP_WIDTH_A=EXP_WIDTH_B=EXP_WIDTH_PRODUCT=5, ROUND=0 unless stated; values are real-valued, raw = value·32):
- Basic real: a = 2.5+0j (raw 80), b = 257.5+0j (raw 8240) → after 3 cycles p_re = 643.75 (raw 20600), p_im = 0, sat = 0.
- Complex: a = 1+2j, b = 3+4j → p = −5+10j (raw −160, 320), no saturation. Also a = b = −1−1j → p = 0+2j.
- Saturation:
  - a = 513, b = 1022 (real) → p_re = 32767 raw, sat_re = 1, overflow_sticky = 1.
  - a = −512, b = 4 → p_re = −32768 raw, sat_re = 1.
  - Pulse clear_flags → overflow_sticky = 0.
- Rounding, a_re raw 1 × b_re raw 16:
  - ROUND=0 → p_re raw 0; ROUND=1 → p_re raw 1.
  - a_re raw −1 × b_re raw 16: ROUND=0 → raw −1; ROUND=1 → raw 0.
- Backpressure:
  - Stream 6 back-to-back inputs; hold out_ready = 0 for 5 cycles mid-stream.
  - Required: in_ready = 0 during the stall, outputs stable, all 6 results delivered in order with none lost or duplicated.
- Reset mid-stream: with 3 transactions in flight, assert reset 1 cycle → out_valid = 0 next cycle, no stale result ever appears, and a new input gives the correct result 3 cycles later.
